signal_diffuser: RTL and testbench
==================================

SIGNAL_DIFFUSER -- requirements
Module: signal_diffuser

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIFF_SHIFT, 2, right-shift applied to the (neighbour average - current) term.
- DECAY_SHIFT, 5, right-shift used for the evaporation term.
- FIFO_DEPTH, 4, number of write-back buffer entries (power of 2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, system clock; all state on its rising edge.
- RESET_SIM, in, 1, asynchronous active-high reset.
- RUN, in, 1, simulation enable.
- newLoc, in, 1, one-Clk pulse per scan advance; qualifies the env cache outputs.
- writeLoc_X, in, X_bits, column of the centre cell.
- writeLoc_Y, in, Y_bits, row of the centre cell.
- surrounding_signals, in, 8 x SIGNAL_bits, neighbours 0..7 (0=up, clockwise, 7=up-left).
- curSignal, in, SIGNAL_bits, centre signal.
- curSugar, in, 1, centre is a sugar source.
- wr_req, out, 1, FIFO head valid.
- wr_X, out, X_bits, write column.
- wr_Y, out, Y_bits, write row.
- wr_signal, out, SIGNAL_bits, new signal value.
- wr_ack, in, 1, memory accepted head this cycle.
- overflow, out, 1, sticky: a result was dropped.

Function
REQ-003 Stage 1 SHALL capture all inputs when newLoc=1 and RUN=1, and set v1=1; otherwise v1=0.
REQ-004 Neighbour validity SHALL be derived from the captured X/Y, never from input values.
- Up-side neighbours (0,1,7) are invalid at Y=0.
- Down-side neighbours (3,4,5) are invalid at Y=PIXELS_Y-1.
- Left-side neighbours (5,6,7) are invalid at X=0.
- Right-side neighbours (1,2,3) are invalid at X=PIXELS_X-1.
REQ-005 Stage 2 SHALL register sum = sum of the valid neighbours, with invalid neighbours contributing 0, width SIGNAL_bits+3 unsigned.
REQ-006 Stage 3 SHALL compute:
- avg = sum>>3.
- d = signed(avg - cur), width SIGNAL_bits+2.
- t = cur + (d>>>DIFF_SHIFT), arithmetic shift.
- n = t - (t>>DECAY_SHIFT).
- n is clamped to [0, 2^SIGNAL_bits-1].
REQ-007 If the captured curSugar=1, the result SHALL be 2^SIGNAL_bits-1 regardless of REQ-006.
REQ-008 Latency SHALL be 3 Clk from the newLoc edge to the FIFO write; wr_req is visible one Clk later if the FIFO was empty.
REQ-009 The FIFO SHALL hold {X, Y, signal} entries; wr_req=1 iff the FIFO is non-empty, and wr_X/wr_Y/wr_signal show the head.
REQ-010 The head SHALL pop on a Clk edge with wr_req=1 and wr_ack=1; wr_ack while empty is ignored.
REQ-011 While wr_req=1 and wr_ack=0, the head outputs SHALL remain stable.
REQ-012 A push and a pop on the same edge SHALL both occur, including when the FIFO is full; the count is unchanged.
REQ-013 A push into a full FIFO with no simultaneous pop SHALL drop the new entry, set overflow=1, and leave existing entries untouched.
REQ-014 overflow SHALL remain 1 until RESET_SIM.
REQ-015 RUN=0 SHALL block new captures only.
- Entries already in stages 2-3 complete.
- The FIFO keeps draining.
REQ-016 Back-to-back newLoc pulses, one per Clk, SHALL be supported at full throughput; the pipeline never stalls.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count or extra pointer bit distinguishing full from empty.

Reset
REQ-018 On RESET_SIM=1, asynchronously:
- v1, v2 and v3 = 0.
- FIFO empty, pointers 0.
- wr_req=0, wr_X=0, wr_Y=0, wr_signal=0, overflow=0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight and buffered entries, with no write after deassertion until a new newLoc.

Structure
REQ-020 SIGNAL_bits, X_bits, Y_bits, PIXELS_X, PIXELS_Y and a wb_entry_t struct {X, Y, signal} SHALL live in the shared params package.
REQ-021 The FIFO SHALL be a sub-module named wb_fifo, parameterised by depth and entry type; the arithmetic stays in signal_diffuser.

Verification (SIGNAL_bits=6, defaults)
REQ-022 Interior cell: cur=0, all neighbours=32, sugar=0 -> wr_signal=8, wr_req rises 4 Clk after newLoc.
REQ-023 Corner X=0,Y=0: neighbours 2,3,4=32, others driven 63 -> wr_signal=3 (the invalid 63s are ignored).
REQ-024 Decay and saturation cases:
- cur=63, all neighbours=63 -> 62.
- cur=40, all neighbours=0 -> 30.
- curSugar=1 with any values -> 63.
REQ-025 wr_ack held 0 across 5 consecutive newLoc pulses -> 4 entries stored, overflow=1, the 5th is lost. Then wr_ack=1 -> 4 pops in order with stable data.
REQ-026 Full FIFO with simultaneous push and ack -> count stays 4, overflow stays 0. RESET_SIM pulsed with 3 entries queued -> wr_req=0 immediately and no stale writes after release.

Source files
------------

// File: rtl/signal_diffuser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | signal_diffuser_pkg                                                         |
// | Shared grid geometry, signal width and write-back entry type for the       |
// | signal diffuser and its write-back FIFO.                                    |
// | Contents: SIGNAL_bits, X_bits, Y_bits, PIXELS_X, PIXELS_Y, wb_entry_t,      |
// |           neighbour direction indices, nbr_valid_mask() helper.            |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package signal_diffuser_pkg;

   localparam int SIGNAL_bits = 6;
   localparam int X_bits      = 5;
   localparam int Y_bits      = 4;
   localparam int PIXELS_X    = 20;
   localparam int PIXELS_Y    = 12;

   localparam logic [SIGNAL_bits-1:0] SIGNAL_MAX = '1;

   // Neighbour numbering: 0 = up, then clockwise, 7 = up-left.
   localparam int NB_UP         = 0;
   localparam int NB_UP_RIGHT   = 1;
   localparam int NB_RIGHT      = 2;
   localparam int NB_DOWN_RIGHT = 3;
   localparam int NB_DOWN       = 4;
   localparam int NB_DOWN_LEFT  = 5;
   localparam int NB_LEFT       = 6;
   localparam int NB_UP_LEFT    = 7;

   typedef struct packed {
      logic [X_bits-1:0]      x;
      logic [Y_bits-1:0]      y;
      logic [SIGNAL_bits-1:0] signal;
   } wb_entry_t;

   // One bit per neighbour; cleared where the neighbour lies off the grid.
   function automatic logic [7:0] nbr_valid_mask(input logic [X_bits-1:0] x,
                                                 input logic [Y_bits-1:0] y);
      logic [7:0] mask;
      mask = 8'hFF;
      if (y == '0) begin
         mask[NB_UP]      = 1'b0;
         mask[NB_UP_RIGHT] = 1'b0;
         mask[NB_UP_LEFT] = 1'b0;
      end
      if (y == Y_bits'(PIXELS_Y - 1)) begin
         mask[NB_DOWN_RIGHT] = 1'b0;
         mask[NB_DOWN]       = 1'b0;
         mask[NB_DOWN_LEFT]  = 1'b0;
      end
      if (x == '0) begin
         mask[NB_DOWN_LEFT] = 1'b0;
         mask[NB_LEFT]      = 1'b0;
         mask[NB_UP_LEFT]   = 1'b0;
      end
      if (x == X_bits'(PIXELS_X - 1)) begin
         mask[NB_UP_RIGHT]   = 1'b0;
         mask[NB_RIGHT]      = 1'b0;
         mask[NB_DOWN_RIGHT] = 1'b0;
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_fifo                                                                     |
// | Write-back buffer between the diffuser pipeline and grid memory.           |
// | Ports: clk, rst (async, active high), push/push_data (new result),         |
// |        pop (consumer accepted head), valid/head (current head entry),     |
// |        overflow (sticky, a push was dropped because the buffer was full). |
// | A simultaneous push and pop is always accepted, even when full.            |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module wb_fifo
   import signal_diffuser_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output logic   valid,
   output entry_t head,
   output logic   overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               is_full;
   logic               is_empty;
   logic               do_pop;
   logic               do_push;

   assign is_full  = (count == CNT_W'(DEPTH));
   assign is_empty = (count == '0);
   // Pop is qualified by non-empty so an ack while empty is ignored.
   assign do_pop   = pop & ~is_empty;
   // A full buffer still accepts a push when the head leaves on the same edge.
   assign do_push  = push & (~is_full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: the head output is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_comb begin
      valid = ~is_empty;
      head  = is_empty ? entry_t'('0) : mem[rd_ptr];
   end

endmodule
`default_nettype wire

// File: rtl/signal_diffuser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | signal_diffuser                                                             |
// | Three-stage diffusion/evaporation pipeline for one grid cell per newLoc,  |
// | feeding a write-back FIFO toward grid memory.                               |
// | Ports: Clk, RESET_SIM (async, active high), RUN, newLoc, writeLoc_X/Y,     |
// |        surrounding_signals, curSignal, curSugar (cell inputs);            |
// |        wr_req/wr_X/wr_Y/wr_signal/wr_ack (write-back handshake);          |
// |        overflow (sticky result-dropped flag).                             |
// | Stage 1 captures, stage 2 sums valid neighbours, stage 3 computes the new |
// | value; the result enters the FIFO on the following edge.                  |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module signal_diffuser
   import signal_diffuser_pkg::*;
#(
   parameter int DIFF_SHIFT  = 2,
   parameter int DECAY_SHIFT = 5,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                        Clk,
   input  logic                        RESET_SIM,
   input  logic                        RUN,
   input  logic                        newLoc,
   input  logic [X_bits-1:0]           writeLoc_X,
   input  logic [Y_bits-1:0]           writeLoc_Y,
   input  logic [7:0][SIGNAL_bits-1:0] surrounding_signals,
   input  logic [SIGNAL_bits-1:0]      curSignal,
   input  logic                        curSugar,
   output logic                        wr_req,
   output logic [X_bits-1:0]           wr_X,
   output logic [Y_bits-1:0]           wr_Y,
   output logic [SIGNAL_bits-1:0]      wr_signal,
   input  logic                        wr_ack,
   output logic                        overflow
);

   localparam int SUM_W = SIGNAL_bits + 3;
   localparam int D_W   = SIGNAL_bits + 2;
   localparam int T_W   = SIGNAL_bits + 3;

   // Stage 1: captured cell
   logic                        v1;
   logic [X_bits-1:0]           x1;
   logic [Y_bits-1:0]           y1;
   logic [7:0][SIGNAL_bits-1:0] nb1;
   logic [SIGNAL_bits-1:0]      cur1;
   logic                        sugar1;

   // Stage 2: neighbour sum
   logic                        v2;
   logic [X_bits-1:0]           x2;
   logic [Y_bits-1:0]           y2;
   logic [SUM_W-1:0]            sum2;
   logic [SIGNAL_bits-1:0]      cur2;
   logic                        sugar2;

   // Stage 3: result
   logic                        v3;
   logic [X_bits-1:0]           x3;
   logic [Y_bits-1:0]           y3;
   logic [SIGNAL_bits-1:0]      res3;

   logic                        capture;
   logic [7:0]                  nb_mask;
   logic [SUM_W-1:0]            sum_c;
   logic [SIGNAL_bits-1:0]      avg;
   logic signed [D_W-1:0]       d;
   logic signed [D_W-1:0]       d_sh;
   logic signed [T_W-1:0]       t;
   logic signed [T_W-1:0]       n;
   logic [SIGNAL_bits-1:0]      n_clamped;
   wb_entry_t                   push_entry;
   wb_entry_t                   head_entry;

   assign capture = newLoc & RUN;

   always_ff @(posedge Clk or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         v1     <= 1'b0;
         x1     <= '0;
         y1     <= '0;
         nb1    <= '0;
         cur1   <= '0;
         sugar1 <= 1'b0;
      end else begin
         v1 <= capture;
         if (capture) begin
            x1     <= writeLoc_X;
            y1     <= writeLoc_Y;
            nb1    <= surrounding_signals;
            cur1   <= curSignal;
            sugar1 <= curSugar;
         end
      end
   end

   // Off-grid neighbours are masked using the captured position only.
   always_comb begin
      nb_mask = nbr_valid_mask(x1, y1);
      sum_c   = '0;
      for (int i = 0; i < 8; i++) begin
         if (nb_mask[i]) sum_c = sum_c + SUM_W'(nb1[i]);
      end
   end

   always_ff @(posedge Clk or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         v2     <= 1'b0;
         x2     <= '0;
         y2     <= '0;
         sum2   <= '0;
         cur2   <= '0;
         sugar2 <= 1'b0;
      end else begin
         v2     <= v1;
         x2     <= x1;
         y2     <= y1;
         sum2   <= sum_c;
         cur2   <= cur1;
         sugar2 <= sugar1;
      end
   end

   // avg of eight neighbours; the headroom of T_W keeps every intermediate
   // exact so clamping sees the true sign and magnitude.
   always_comb begin
      avg  = SIGNAL_bits'(sum2 >> 3);
      d    = $signed({2'b00, avg}) - $signed({2'b00, cur2});
      d_sh = d >>> DIFF_SHIFT;
      t    = $signed({3'b000, cur2}) + $signed({d_sh[D_W-1], d_sh});
      n    = t - (t >>> DECAY_SHIFT);
      if (n[T_W-1])
         n_clamped = '0;
      else if (|n[T_W-2:SIGNAL_bits])
         n_clamped = SIGNAL_MAX;
      else
         n_clamped = n[SIGNAL_bits-1:0];
   end

   always_ff @(posedge Clk or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         v3   <= 1'b0;
         x3   <= '0;
         y3   <= '0;
         res3 <= '0;
      end else begin
         v3   <= v2;
         x3   <= x2;
         y3   <= y2;
         res3 <= sugar2 ? SIGNAL_MAX : n_clamped;
      end
   end

   always_comb begin
      push_entry.x      = x3;
      push_entry.y      = y3;
      push_entry.signal = res3;
   end

   wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (wb_entry_t)
   ) u_wb_fifo (
      .clk       (Clk),
      .rst       (RESET_SIM),
      .push      (v3),
      .push_data (push_entry),
      .pop       (wr_ack),
      .valid     (wr_req),
      .head      (head_entry),
      .overflow  (overflow)
   );

   assign wr_X      = head_entry.x;
   assign wr_Y      = head_entry.y;
   assign wr_signal = head_entry.signal;

endmodule
`default_nettype wire

// File: tb/tb_signal_diffuser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_signal_diffuser                                                          |
// | Self-checking bench: directed cases plus randomized traffic compared      |
// | against a queue-based reference of pipeline latency, FIFO and arithmetic. |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_signal_diffuser;
   import signal_diffuser_pkg::*;

   localparam int DEPTH   = 4;
   localparam int DIFF    = 2;
   localparam int DECAY   = 5;
   localparam int SMAX    = (1 << SIGNAL_bits) - 1;
   localparam int LATENCY = 3;

   logic                        Clk = 1'b0;
   logic                        RESET_SIM;
   logic                        RUN;
   logic                        newLoc;
   logic [X_bits-1:0]           writeLoc_X;
   logic [Y_bits-1:0]           writeLoc_Y;
   logic [7:0][SIGNAL_bits-1:0] surrounding_signals;
   logic [SIGNAL_bits-1:0]      curSignal;
   logic                        curSugar;
   logic                        wr_req;
   logic [X_bits-1:0]           wr_X;
   logic [Y_bits-1:0]           wr_Y;
   logic [SIGNAL_bits-1:0]      wr_signal;
   logic                        wr_ack;
   logic                        overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int due;
      int x;
      int y;
      int sig;
   } ent_t;

   ent_t mq[$];     // reference FIFO contents
   ent_t pend[$];   // captured cells waiting for their FIFO write edge
   bit   m_ovf;
   int   cyc;

   signal_diffuser #(
      .DIFF_SHIFT  (DIFF),
      .DECAY_SHIFT (DECAY),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .Clk                 (Clk),
      .RESET_SIM           (RESET_SIM),
      .RUN                 (RUN),
      .newLoc              (newLoc),
      .writeLoc_X          (writeLoc_X),
      .writeLoc_Y          (writeLoc_Y),
      .surrounding_signals (surrounding_signals),
      .curSignal           (curSignal),
      .curSugar            (curSugar),
      .wr_req              (wr_req),
      .wr_X                (wr_X),
      .wr_Y                (wr_Y),
      .wr_signal           (wr_signal),
      .wr_ack              (wr_ack),
      .overflow            (overflow)
   );

   always #5 Clk = ~Clk;

   // New cell value from the diffusion rules, using grid geometry directly.
   function automatic int ref_value(input int x, input int y, input int cur,
                                    input logic [7:0][SIGNAL_bits-1:0] nb, input bit sugar);
      int dx[8];
      int dy[8];
      int sum, avg, d, t, n;
      dx = '{0, 1, 1, 1, 0, -1, -1, -1};
      dy = '{-1, -1, 0, 1, 1, 1, 0, -1};
      if (sugar) return SMAX;
      sum = 0;
      for (int i = 0; i < 8; i++) begin
         if (x + dx[i] >= 0 && x + dx[i] < PIXELS_X && y + dy[i] >= 0 && y + dy[i] < PIXELS_Y)
            sum += int'(nb[i]);
      end
      avg = sum / 8;
      d   = avg - cur;
      t   = cur + (d >>> DIFF);
      n   = t - (t >>> DECAY);
      if (n < 0) n = 0;
      if (n > SMAX) n = SMAX;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit   popped;
      ent_t e;
      popped = (wr_ack === 1'b1) && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         if (mq.size() < DEPTH) mq.push_back(e);
         else m_ovf = 1'b1;
      end
      if (newLoc && RUN) begin
         e.due = cyc + LATENCY;
         e.x   = int'(writeLoc_X);
         e.y   = int'(writeLoc_Y);
         e.sig = ref_value(int'(writeLoc_X), int'(writeLoc_Y), int'(curSignal),
                           surrounding_signals, curSugar);
         pend.push_back(e);
      end
      cyc++;
   endtask

   task automatic compare_all();
      chk("wr_req", 32'(wr_req), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("wr_X", 32'(wr_X), 32'(mq[0].x));
         chk("wr_Y", 32'(wr_Y), 32'(mq[0].y));
         chk("wr_signal", 32'(wr_signal), 32'(mq[0].sig));
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic rand_cell(input bit edges);
      int r;
      r = $urandom_range(0, 3);
      if (edges && r == 0)      writeLoc_X = '0;
      else if (edges && r == 1) writeLoc_X = X_bits'(PIXELS_X - 1);
      else                      writeLoc_X = X_bits'($urandom_range(0, PIXELS_X - 1));
      r = $urandom_range(0, 3);
      if (edges && r == 0)      writeLoc_Y = '0;
      else if (edges && r == 1) writeLoc_Y = Y_bits'(PIXELS_Y - 1);
      else                      writeLoc_Y = Y_bits'($urandom_range(0, PIXELS_Y - 1));
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'($urandom_range(0, SMAX));
      curSignal = SIGNAL_bits'($urandom_range(0, SMAX));
      curSugar  = ($urandom_range(0, 7) == 0);
   endtask

   // One isolated cell; checks exact latency and the literal result value.
   task automatic single(input string tag, input int x, input int y, input int cur,
                         input bit sugar, input int expv);
      writeLoc_X = X_bits'(x);
      writeLoc_Y = Y_bits'(y);
      curSignal  = SIGNAL_bits'(cur);
      curSugar   = sugar;
      newLoc     = 1'b1;
      RUN        = 1'b1;
      wr_ack     = 1'b0;
      step();
      chk({tag, "_lat0"}, 32'(wr_req), 32'd0);
      newLoc = 1'b0;
      rand_cell(1'b0);   // scramble inputs: the result must come from the capture
      step();
      chk({tag, "_lat1"}, 32'(wr_req), 32'd0);
      step();
      chk({tag, "_lat2"}, 32'(wr_req), 32'd0);
      step();
      chk({tag, "_req"}, 32'(wr_req), 32'd1);
      chk({tag, "_val"}, 32'(wr_signal), 32'(expv));
      chk({tag, "_x"}, 32'(wr_X), 32'(x));
      chk({tag, "_y"}, 32'(wr_Y), 32'(y));
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
   endtask

   task automatic reset_pulse(input string tag);
      #2;
      RESET_SIM = 1'b1;
      #1;
      chk({tag, "_req"}, 32'(wr_req), 32'd0);
      chk({tag, "_x"}, 32'(wr_X), 32'd0);
      chk({tag, "_y"}, 32'(wr_Y), 32'd0);
      chk({tag, "_sig"}, 32'(wr_signal), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      mq.delete();
      pend.delete();
      m_ovf = 1'b0;
      @(negedge Clk);
      RESET_SIM = 1'b0;
   endtask

   initial begin
      int n;
      RESET_SIM  = 1'b1;
      RUN        = 1'b0;
      newLoc     = 1'b0;
      writeLoc_X = '0;
      writeLoc_Y = '0;
      surrounding_signals = '0;
      curSignal  = '0;
      curSugar   = 1'b0;
      wr_ack     = 1'b0;
      m_ovf      = 1'b0;
      cyc        = 0;
      #12;
      chk("rst_req", 32'(wr_req), 32'd0);
      chk("rst_x", 32'(wr_X), 32'd0);
      chk("rst_y", 32'(wr_Y), 32'd0);
      chk("rst_sig", 32'(wr_signal), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(negedge Clk);
      RESET_SIM = 1'b0;
      step();

      // Interior diffusion
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'(32);
      single("interior", 5, 5, 0, 1'b0, 8);

      // Corner X=0,Y=0: only neighbours 2,3,4 are on the grid
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'(SMAX);
      surrounding_signals[2] = SIGNAL_bits'(32);
      surrounding_signals[3] = SIGNAL_bits'(32);
      surrounding_signals[4] = SIGNAL_bits'(32);
      single("corner00", 0, 0, 0, 1'b0, 3);

      // Opposite corner: only neighbours 0,6,7 are on the grid
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'(SMAX);
      surrounding_signals[0] = SIGNAL_bits'(32);
      surrounding_signals[6] = SIGNAL_bits'(32);
      surrounding_signals[7] = SIGNAL_bits'(32);
      single("corner_max", PIXELS_X - 1, PIXELS_Y - 1, 0, 1'b0, 3);

      // Decay at full scale, decay toward zero, sugar saturation
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'(SMAX);
      single("decay63", 7, 3, 63, 1'b0, 62);
      surrounding_signals = '0;
      single("decay40", 9, 8, 40, 1'b0, 30);
      for (int i = 0; i < 8; i++) surrounding_signals[i] = SIGNAL_bits'($urandom_range(0, SMAX));
      single("sugar", 3, 0, 17, 1'b1, 63);

      // Ack while empty is ignored
      wr_ack = 1'b1;
      step();
      step();
      wr_ack = 1'b0;

      // Five back-to-back cells with no ack: four kept, fifth dropped
      RUN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_cell(1'b1);
         newLoc = 1'b1;
         step();
      end
      newLoc = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("full_req", 32'(wr_req), 32'd1);
      wr_ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drained_req", 32'(wr_req), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      wr_ack = 1'b0;

      // Full FIFO streaming: push and pop on the same edges
      reset_pulse("rst_clr");
      for (int i = 0; i < 11; i++) begin
         newLoc = (i < 8);
         if (i < 8) rand_cell(1'b1);
         wr_ack = (i >= 7);
         step();
      end
      newLoc = 1'b0;
      wr_ack = 1'b0;
      chk("stream_ovf", 32'(overflow), 32'd0);
      chk("stream_req", 32'(wr_req), 32'd1);
      n = 0;
      wr_ack = 1'b1;
      while (wr_req === 1'b1 && n < 10) begin
         step();
         n++;
      end
      wr_ack = 1'b0;
      chk("stream_count", 32'(n), 32'd4);

      // Reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         rand_cell(1'b1);
         newLoc = 1'b1;
         step();
      end
      newLoc = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("three_queued", 32'(wr_req), 32'd1);
      reset_pulse("rst_mid");
      for (int i = 0; i < 6; i++) step();
      chk("no_stale", 32'(wr_req), 32'd0);

      // RUN=0 blocks captures, in-flight entry still completes
      RUN = 1'b1;
      rand_cell(1'b1);
      newLoc = 1'b1;
      step();
      RUN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_cell(1'b1);
         step();
      end
      newLoc = 1'b0;
      chk("run0_req", 32'(wr_req), 32'd1);
      wr_ack = 1'b1;
      step();
      step();
      chk("run0_one", 32'(wr_req), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_cell(1'b1);
         newLoc = ($urandom_range(0, 9) < 6);
         RUN    = ($urandom_range(0, 9) != 0);
         wr_ack = $urandom_range(0, 1);
         step();
      end
      newLoc = 1'b0;
      wr_ack = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("final_empty", 32'(wr_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
